// File: rtl/bram_row_fetcher_pkg.sv
// Shared types and constants for the BRAM row fetcher.
// Define BRAM_OUTREG_EN when the BRAM output register is enabled (read latency 2).
package bram_row_fetcher_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} fetch_state_t;

  localparam int DEF_REG_WIDTH   = 16;
  localparam int DEF_MATRIX_SIZE = 4;
  localparam int DEF_ADDR_WIDTH  = 8;

`ifdef BRAM_OUTREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

endpackage

// File: rtl/bram_row_fetcher_rd_valid_pipe.sv
// Issue-valid shift register, LAT deep: vld_out marks the cycle read data is valid.
module rd_valid_pipe #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic issue,
  output logic vld_out,
  output logic in_flight
);

  logic [LAT:1] vld_pipe;

  generate
    if (LAT == 1) begin : g_lat1
      always_ff @(posedge clk) begin
        if (reset) vld_pipe <= '0;
        else       vld_pipe <= issue;
      end
    end else begin : g_latn
      always_ff @(posedge clk) begin
        if (reset) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[LAT-1:1], issue};
      end
    end
  endgenerate

  assign vld_out   = vld_pipe[LAT];
  assign in_flight = |vld_pipe;

endmodule

// File: rtl/bram_row_fetcher.sv
// Fetches MATRIX_SIZE consecutive BRAM rows per start and presents each as a one-cycle row_valid.
// Read latency follows BRAM_OUTREG_EN (see bram_row_fetcher_pkg).
module bram_row_fetcher
  import bram_row_fetcher_pkg::*;
#(
  parameter int REG_WIDTH   = DEF_REG_WIDTH,
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter int BRAM_DEPTH  = MATRIX_SIZE * REG_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  hold,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [BRAM_DEPTH-1:0] bram_dout,
  output logic [BRAM_DEPTH-1:0] row_data,
  output logic                  row_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int KW = $clog2(MATRIX_SIZE) + 1;
  localparam logic [KW-1:0] K_LAST = KW'(MATRIX_SIZE - 1);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [KW-1:0]         k;
  logic                  issue, pipe_out, in_flight;

  // hold gates the read in the same cycle so a paused issue never reaches the BRAM
  assign issue     = (state == FETCH) && !hold;
  assign bram_en   = issue;
  assign bram_addr = base_q + ADDR_WIDTH'(k);
  assign busy      = (state != IDLE);

  rd_valid_pipe #(.LAT(RD_LAT)) u_rd_valid_pipe (
    .clk       (clk),
    .reset     (reset),
    .issue     (issue),
    .vld_out   (pipe_out),
    .in_flight (in_flight)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      base_q    <= '0;
      k         <= '0;
      row_data  <= '0;
      row_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      row_valid <= pipe_out;
      if (pipe_out) row_data <= bram_dout;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          base_q <= base_addr;
          k      <= '0;
          state  <= FETCH;
        end
        FETCH: if (!hold) begin
          k <= k + KW'(1);
          if (k == K_LAST) state <= DRAIN;
        end
        // pipe empty means the final capture happened on the previous edge
        DRAIN: if (!in_flight) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_row_fetcher.sv
// Self-checking bench for bram_row_fetcher: cycle table for the basic fetch plus
// hand sequences for hold, wrap, reset and ignored starts, all backed by a read/row scoreboard.
module tb_bram_row_fetcher;
  import bram_row_fetcher_pkg::*;

  localparam int L = RD_LAT;

  logic        clk, reset, start, hold;
  logic [7:0]  base_addr, bram_addr;
  logic        bram_en, row_valid, busy, done;
  logic [63:0] bram_dout, row_data;

  bram_row_fetcher dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .hold(hold),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
    .row_data(row_data), .row_valid(row_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [7:0] a);
    return {8'hA0, a, 8'hB1, a ^ 8'hFF, 8'hC2, a + 8'd1, 8'hD3, ~a};
  endfunction

  // BRAM model: registered read, optional output register
  logic [63:0] s1, s2;
  always @(posedge clk) begin
    if (bram_en) s1 <= mem_word(bram_addr);
    s2 <= s1;
  end
  assign bram_dout = (L == 2) ? s2 : s1;

  int checks = 0, failures = 0;
  logic [7:0]  addr_q[$];
  logic [63:0] row_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_fetch(input logic [7:0] b);
    for (int i = 0; i < 4; i++) begin
      addr_q.push_back(b + 8'(i));
      row_q.push_back(mem_word(b + 8'(i)));
    end
  endtask

  // sample at negedge and run the scoreboard
  task automatic sample();
    @(negedge clk);
    if (bram_en) begin
      checks++;
      if (addr_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read addr=%h expected=no read", bram_addr);
      end else begin
        logic [7:0] ea;
        ea = addr_q.pop_front();
        checks--;
        chk("rd_addr", 64'(bram_addr), 64'(ea));
      end
    end
    if (row_valid) begin
      checks++;
      if (row_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_row_valid data=%h expected=no row", row_data);
      end else begin
        logic [63:0] er;
        er = row_q.pop_front();
        checks--;
        chk("row_data", row_data, er);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  logic       en_log[0:39], rv_log[0:39], dn_log[0:39], bz_log[0:39];
  logic [7:0] ad_log[0:39];

  task automatic run_seq(input logic [7:0] b, input logic [39:0] hold_m, input logic [39:0] start_m,
                         input logic [39:0] rst_m, input int ncyc, input bit exp_fetch);
    if (exp_fetch) push_fetch(b);
    for (int c = 0; c < ncyc; c++) begin
      start = start_m[c]; hold = hold_m[c]; reset = rst_m[c]; base_addr = b;
      sample();
      en_log[c] = bram_en; ad_log[c] = bram_addr; rv_log[c] = row_valid;
      dn_log[c] = done;    bz_log[c] = busy;
      if (reset) begin addr_q.delete(); row_q.delete(); end
      adv();
    end
    start = 0; hold = 0; reset = 0;
  endtask

  function automatic int count(input int kind, input int from, input int to);
    int n = 0;
    for (int c = from; c < to; c++)
      n += (kind == 0) ? int'(rv_log[c]) : int'(dn_log[c]);
    return n;
  endfunction

  function automatic int first_done(input int ncyc);
    for (int c = 0; c < ncyc; c++) if (dn_log[c]) return c;
    return -1;
  endfunction

  typedef struct {
    logic        start;
    logic [7:0]  base;
    logic        e_en;
    logic [7:0]  e_addr;
    logic        e_rv;
    logic [63:0] e_row;
    logic        e_done;
    logic        e_busy;
  } vec_t;

  vec_t tbl[0:11];
  int   nt;

  initial begin
    start = 0; hold = 0; reset = 1; base_addr = 8'h00;
    adv(); adv();
    reset = 0;
    sample();
    chk("rst_bram_en", 64'(bram_en), 0);
    chk("rst_bram_addr", 64'(bram_addr), 0);
    chk("rst_row_data", row_data, 0);
    chk("rst_row_valid", 64'(row_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    adv();

    // basic fetch, base 0x10, start in cycle 0
    nt = 9 + L;
    for (int i = 0; i < nt; i++) begin
      tbl[i].start  = (i == 0);
      tbl[i].base   = 8'h10;
      tbl[i].e_en   = (i >= 1 && i <= 4);
      tbl[i].e_addr = 8'h10 + 8'(i - 1);
      tbl[i].e_rv   = (i >= 2 + L && i <= 5 + L);
      tbl[i].e_row  = mem_word(8'h10 + 8'(i - 2 - L));
      tbl[i].e_done = (i == 6 + L);
      tbl[i].e_busy = (i >= 1 && i <= 6 + L);
    end
    push_fetch(8'h10);
    for (int i = 0; i < nt; i++) begin
      start = tbl[i].start; base_addr = tbl[i].base;
      sample();
      chk($sformatf("tbl%0d_en", i), 64'(bram_en), 64'(tbl[i].e_en));
      if (tbl[i].e_en) chk($sformatf("tbl%0d_addr", i), 64'(bram_addr), 64'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_rv", i), 64'(row_valid), 64'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk($sformatf("tbl%0d_row", i), row_data, tbl[i].e_row);
      chk($sformatf("tbl%0d_done", i), 64'(done), 64'(tbl[i].e_done));
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
      adv();
    end
    start = 0;
    chk("row_data_held", row_data, mem_word(8'h13));

    // hold in cycles 2-3
    run_seq(8'h10, 40'h0C, 40'h1, 40'h0, 12 + L, 1);
    chk("hold_en_c2", 64'(en_log[2]), 0);
    chk("hold_en_c3", 64'(en_log[3]), 0);
    chk("hold_en_c4", 64'(en_log[4]), 1);
    chk("hold_addr_c4", 64'(ad_log[4]), 64'h11);
    chk("hold_rv_count", 64'(count(0, 0, 12 + L)), 4);
    chk("hold_done_cycle", 64'(first_done(12 + L)), 64'(8 + L));

    // hold has no effect once draining
    run_seq(8'h50, 40'hFE0, 40'h1, 40'h0, 10 + L, 1);
    chk("drain_hold_done_cycle", 64'(first_done(10 + L)), 64'(6 + L));

    // address wrap
    run_seq(8'hFE, 40'h0, 40'h1, 40'h0, 10 + L, 1);
    chk("wrap_addr_c3", 64'(ad_log[3]), 64'h00);
    chk("wrap_addr_c4", 64'(ad_log[4]), 64'h01);
    chk("wrap_rv_count", 64'(count(0, 0, 10 + L)), 4);

    // reset in cycle 3 discards in-flight reads
    run_seq(8'h10, 40'h0, 40'h1, 40'h8, 12, 1);
    chk("rstmid_busy_c4", 64'(bz_log[4]), 0);
    chk("rstmid_rv_after", 64'(count(0, 4, 12)), 0);
    chk("rstmid_done_after", 64'(count(1, 0, 12)), 0);
    run_seq(8'h20, 40'h0, 40'h1, 40'h0, 10 + L, 1);
    chk("restart_done_cycle", 64'(first_done(10 + L)), 64'(6 + L));

    // starts during FETCH and DONE are ignored
    run_seq(8'h30, 40'h0, (40'h1 | 40'h4 | (40'h1 << (6 + L))), 40'h0, 12 + L, 1);
    chk("ign_done_count", 64'(count(1, 0, 12 + L)), 1);
    chk("ign_rv_count", 64'(count(0, 0, 12 + L)), 4);
    chk("ign_busy_end", 64'(bz_log[11 + L]), 0);

    // start with reset stays idle
    run_seq(8'h40, 40'h0, 40'h1, 40'h1, 4, 0);
    chk("startrst_busy", 64'(bz_log[1]), 0);
    chk("startrst_en", 64'(en_log[1] | en_log[2] | en_log[3]), 0);

    chk("addr_q_empty", 64'(addr_q.size()), 0);
    chk("row_q_empty", 64'(row_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_row_fetcher.md
BRAM_ROW_FETCHER -- requirements
Module: bram_row_fetcher

Interface
REQ-001 Parameters SHALL be:
  - REG_WIDTH, default 16: width of one matrix element.
  - MATRIX_SIZE, default 4: number of rows fetched per start, and elements per row.
  - BRAM_DEPTH, default MATRIX_SIZE*REG_WIDTH: width of one BRAM row.
  - ADDR_WIDTH, default 8: BRAM address width.
REQ-002 Ports SHALL be:
  - clk  in  1: the single clock; all logic is on posedge.
  - reset  in  1: synchronous, active-high.
  - start  in  1: request to fetch one matrix.
  - base_addr  in  ADDR_WIDTH: address of the first row.
  - hold  in  1: pauses issue of new reads.
  - bram_en  out  1: BRAM read enable.
  - bram_addr  out  ADDR_WIDTH: BRAM read address.
  - bram_dout  in  BRAM_DEPTH: BRAM read data.
  - row_data  out  BRAM_DEPTH: captured row; feeds data_bram of the decoder stage.
  - row_valid  out  1: row_data is valid this cycle; drives the decoder enable.
  - busy  out  1: high in every state except IDLE.
  - done  out  1: one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have four states: IDLE, FETCH, DRAIN, DONE.
REQ-004 IDLE: start=1 SHALL latch base_addr, clear the row counter k, and move to FETCH; start is ignored in all other states.
REQ-005 FETCH, hold=0: drive bram_en=1 and bram_addr=base+k, then increment k; after the issue with k=MATRIX_SIZE-1, move to DRAIN.
REQ-006 FETCH, hold=1: bram_en=0, k unchanged, stay in FETCH; reads already in flight SHALL still complete.
REQ-007 Address arithmetic SHALL be modulo 2^ADDR_WIDTH (base 0xFE with 4 rows reads 0xFE, 0xFF, 0x00, 0x01).
REQ-008 Read latency L SHALL be 1 cycle (2 cycles with BRAM_OUTREG_EN); bram_dout is valid L cycles after the cycle in which bram_en was high.
REQ-009 The block SHALL sample bram_dout into row_data at the cycle it becomes valid; row_valid SHALL be high for exactly one cycle, L+1 cycles after the matching issue.
REQ-010 row_data SHALL hold its last value while row_valid=0.
REQ-011 With hold=0 throughout, row_valid SHALL be high for exactly MATRIX_SIZE consecutive cycles, in address order.
REQ-012 DRAIN: stay until no read is in flight and the last row_valid has been produced, then move to DONE.
REQ-013 DONE: done=1 for one cycle (the cycle after the last row_valid), then move to IDLE; a start asserted during DONE is ignored.
REQ-014 hold SHALL have no effect in DRAIN or DONE.

Reset
REQ-015 reset=1 SHALL force, on the next edge: state=IDLE, k=0, all in-flight valid bits cleared, bram_en=0, bram_addr=0, row_data=0, row_valid=0, busy=0, done=0.
REQ-016 Reset mid-operation SHALL discard in-flight reads, with no row_valid afterwards.
REQ-017 If reset and start are high in the same cycle, reset SHALL win.

Configuration
REQ-018 Macro BRAM_OUTREG_EN:
  - Defined: L=2, matching a BRAM with its output register enabled.
  - Undefined: L=1.
  - The in-flight pipeline depth SHALL follow L; nothing else changes.

Structure
REQ-019 A shared package SHALL hold:
  - the fetch-state enum typedef (IDLE/FETCH/DRAIN/DONE);
  - the default REG_WIDTH, MATRIX_SIZE and ADDR_WIDTH constants;
  - the read-latency constant derived from BRAM_OUTREG_EN.
REQ-020 A sub-module rd_valid_pipe SHALL hold the L-deep issue-valid shift register and report whether any read is in flight.

Verification
REQ-021 Basic fetch (L=1): base_addr=0x10, start in cycle 0 -> bram_addr 0x10..0x13 in cycles 1-4, row_valid in cycles 3-6 with matching bram_dout, done=1 in cycle 7 only.
REQ-022 Output register: same stimulus with BRAM_OUTREG_EN -> row_valid in cycles 4-7, done in cycle 8.
REQ-023 Hold: hold=1 in cycles 2-3 -> bram_addr 0x11 in cycle 4, still exactly 4 row_valid pulses in address order, done delayed by 2 cycles.
REQ-024 Address wrap: base_addr=0xFE -> reads of 0xFE, 0xFF, 0x00, 0x01.
REQ-025 Reset mid-operation: reset in cycle 3 -> no further row_valid or done, busy=0, and a new start is accepted afterwards.
REQ-026 Ignored starts: start asserted in FETCH and in DONE -> no second fetch; start together with reset -> stays IDLE.
